// File: rtl/rca_seq32.sv
// Sequential 32-bit add/subtract built from one time-shared 8-bit ripple-carry slice.
// Define RCA_SEQ32_OVF_EN to add the registered signed-overflow output ovf.

module rca8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);

   // Bit-serial carry chain, one full adder per bit
   always_comb begin : ripple
      logic c;
      c = ci;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

module rca_seq32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum,
   output logic        cout,
`ifdef RCA_SEQ32_OVF_EN
   output logic        ovf,
`endif
   output logic        busy
);

   localparam int unsigned W  = 32;
   localparam int unsigned SW = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           c_q, c_d;
   logic [1:0]     k_q, k_d;
   logic           cout_q, cout_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;
   logic [SW-1:0]  slice_s;
   logic           slice_co;
`ifdef RCA_SEQ32_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   // The single shared slice, steered by k to bits 8k+7:8k
   rca8 u_rca8 (
      .a  (a_q[{k_q, 3'b000} +: SW]),
      .b  (b_q[{k_q, 3'b000} +: SW]),
      .ci (c_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         c_q         <= 1'b0;
         k_q         <= 2'd0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef RCA_SEQ32_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         c_q         <= c_d;
         k_q         <= k_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef RCA_SEQ32_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_d     = c_q;
      k_d     = k_q;
      cout_d  = cout_q;
`ifdef RCA_SEQ32_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction folds into the add as A + ~B + 1
               state_d = RUN;
               a_d     = a;
               b_d     = b ^ {W{sub}};
               c_d     = sub;
               k_d     = 2'd0;
            end
         end
         RUN: begin
            sum_d[{k_q, 3'b000} +: SW] = slice_s;
            c_d = slice_co;
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = DONE;
               cout_d  = slice_co;
`ifdef RCA_SEQ32_OVF_EN
               ovf_d   = (a_q[W-1] == b_q[W-1]) & (slice_s[SW-1] != a_q[W-1]);
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef RCA_SEQ32_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_seq32.sv
// Directed + random bench for rca_seq32 against an arithmetic reference model.

module tb_rca_seq32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        busy;
`ifdef RCA_SEQ32_OVF_EN
   logic        ovf;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   rca_seq32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef RCA_SEQ32_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference result {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
      logic [31:0] s;
      logic        c, o;
      longint      sr;
      if (!ms) begin
         s  = ma + mb;
         c  = (({32'd0, ma} + {32'd0, mb}) > 64'h0000_0000_FFFF_FFFF);
         sr = longint'($signed(ma)) + longint'($signed(mb));
      end else begin
         s  = ma - mb;
         c  = (ma >= mb);
         sr = longint'($signed(ma)) - longint'($signed(mb));
      end
      o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {o, c, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ta; b = tb; sub = ts;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
   endtask

   task automatic finish_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      logic [33:0] m;
      m = model(ta, tb, ts);
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_early_valid", 32'(out_valid), 32'd0);
         a = $urandom; b = $urandom; sub = 1'($urandom);
      end
      @(posedge clk); #1;
      chk("out_valid_t4", 32'(out_valid), 32'd1);
      chk("sum", sum, m[31:0]);
      chk("cout", 32'(cout), 32'(m[32]));
`ifdef RCA_SEQ32_OVF_EN
      chk("ovf", 32'(ovf), 32'(m[33]));
`endif
   endtask

   task automatic drain(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      logic [33:0] m;
      m = model(ta, tb, ts);
      @(posedge clk); #1;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("ready_back", 32'(in_ready), 32'd1);
      chk("sum_hold", sum, m[31:0]);
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      start_op(ta, tb, ts);
      finish_op(ta, tb, ts);
      drain(ta, tb, ts);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rb, na, nb;
      logic        rs;
      logic [33:0] m;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef RCA_SEQ32_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;

      // Directed corner cases; first accept lands on the first edge after reset release
      run_op(32'h0000_0001, 32'h0000_0002, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1);

      // Back-pressure: result held in DONE while a new request waits
      start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
      out_ready = 1'b0;
      finish_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
      m  = model(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
      na = 32'h00FF_00FF; nb = 32'hFF00_FF01;
      in_valid = 1'b1; a = na; b = nb; sub = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", sum, m[31:0]);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_not_taken", 32'(busy), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pending_taken", 32'(busy), 32'd1);
      finish_op(na, nb, 1'b1);
      drain(na, nb, 1'b1);

      // Reset during slice k=2 abandons the operation
      start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", sum, 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      #1;
      rst_n = 1'b1;
      run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);

      // Random operands with occasional boundary values
      for (int i = 0; i < 24; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         if (i % 6 == 0) ra = 32'hFFFF_FFFF;
         if (i % 7 == 0) rb = 32'h8000_0000;
         run_op(ra, rb, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rca_seq32.md
RCA_SEQ32 -- requirements
Module: rca_seq32

Interface
REQ-001 No parameters; the datapath is fixed at 32 bits, processed as four 8-bit slices.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 sub  input  1  0: A+B; 1: A-B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  32  registered result.
REQ-012 cout  output  1  registered carry out of bit 31 (for sub, 1 = no borrow).
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL instantiate exactly one 8-bit ripple-carry slice (rca8), time-shared across four cycles.
REQ-015 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on in_valid & in_ready.
- RUN->DONE after the 4th slice.
- DONE->IDLE on out_ready.
REQ-016 in_ready SHALL equal 1 only in IDLE; requests in RUN or DONE are not accepted.
REQ-017 On accept, the block SHALL latch:
- a
- b XOR {32{sub}}
- carry register = sub
- slice index = 0
REQ-018 In RUN, each cycle SHALL compute slice k (bits 8k+7:8k) from latched A, latched B' and the carry register.
- Write the 8-bit result into sum[8k+7:8k].
- Load the slice carry-out into the carry register.
- Increment k.
REQ-019 k SHALL run 0,1,2,3 and wrap to 0; the k=3 cycle loads cout and transitions to DONE.
REQ-020 Latency: handshake at edge T.
- Slices written at edges T+1 to T+4.
- out_valid = 1 after edge T+4.
REQ-021 out_valid SHALL be 1 only in DONE.
- sum and cout are stable while out_valid = 1.
- sum and cout hold after out_valid falls, until the next accept.
REQ-022 If out_ready is high at entry to DONE, the result SHALL still be presented for one cycle before returning to IDLE.
REQ-023 The a, b and sub inputs SHALL be ignored except on the accept edge; changes during RUN do not affect the result.
REQ-024 Arithmetic is modulo 2^32.
- Add: cout = unsigned carry.
- Sub: cout = 1 when A >= B unsigned.

Reset
REQ-025 While rst_n = 0, the block SHALL asynchronously force:
- state = IDLE
- in_ready = 1
- out_valid = 0
- busy = 0
- sum = 0
- cout = 0
- carry register = 0
- k = 0
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result is presented after deassertion.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro RCA_SEQ32_OVF_EN SHALL control signed-overflow reporting.
REQ-029 With RCA_SEQ32_OVF_EN defined:
- Output ovf (1 bit) is registered on the k=3 cycle.
- ovf = (A[31] == B'[31]) & (sum[31] != A[31]).
- ovf resets to 0 and is valid with out_valid.
REQ-030 Without RCA_SEQ32_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 A=0x0000_0001, B=0x0000_0002, sub=0, out_ready=1 -> out_valid 4 edges after accept, sum=0x0000_0003, cout=0.
REQ-032 A=0xFFFF_FFFF, B=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1; carry ripples through all four slices.
REQ-033 A=0x0000_0005, B=0x0000_0007, sub=1 -> sum=0xFFFF_FFFE, cout=0; with OVF_EN, ovf=0.
REQ-034 A=0x7FFF_FFFF, B=0x0000_0001, sub=0, OVF_EN defined -> sum=0x8000_0000, ovf=1.
REQ-035 out_ready held 0 for 10 cycles in DONE, in_valid=1 with new operands -> out_valid and sum stable, in_ready=0, new request not taken until the cycle after out_ready=1.
REQ-036 rst_n pulsed low during RUN slice k=2 -> out_valid=0, sum=0, in_ready=1 immediately; the next request completes correctly.
